syn_fifo_param: RTL and testbench
=================================

// Module: syn_fifo_param
// PURPOSE
//  Parametrised single-clock FIFO. Storage is internal; no external dual-port RAM.
//  Replaces the fixed single-rate FIFO between producer/consumer blocks in the clk domain.
//  Adds true full at RAM_DEPTH entries, fill count, almost-full/empty thresholds,
//  overflow/underflow pulses and read-valid strobe.
// PARAMETERS
//  DATA_WIDTH  8               word width in bits
//  ADDR_WIDTH  8               pointer width; RAM_DEPTH = 1<<ADDR_WIDTH
//  RAM_DEPTH   1<<ADDR_WIDTH   derived; do not override
//  AF_LEVEL    RAM_DEPTH-4     almost_full when fill_count >= AF_LEVEL
//  AE_LEVEL    4               almost_empty when fill_count <= AE_LEVEL
// PORTS
//  clk           in   1             clock, all logic on posedge
//  rst           in   1             synchronous reset, active-high
//  wr_cs         in   1             write-side chip select
//  wr_en         in   1             write request (effective only with wr_cs)
//  data_in       in   DATA_WIDTH    write data
//  rd_cs         in   1             read-side chip select
//  rd_en         in   1             read request (effective only with rd_cs)
//  data_out      out  DATA_WIDTH    read data
//  rd_valid      out  1             data_out carries a newly popped/presented word
//  full          out  1             fill_count == RAM_DEPTH
//  empty         out  1             fill_count == 0
//  almost_full   out  1             fill_count >= AF_LEVEL
//  almost_empty  out  1             fill_count <= AE_LEVEL
//  fill_count    out  ADDR_WIDTH+1  number of stored words, 0..RAM_DEPTH
//  overflow      out  1             1-cycle pulse: write was rejected
//  underflow     out  1             1-cycle pulse: read was rejected
// BEHAVIOUR
//  - wr_req = wr_cs&wr_en; rd_req = rd_cs&rd_en. wr_acc = wr_req & !full; rd_acc = rd_req & !empty.
//  - full/empty sampled from current registered count; full+read does NOT admit a same-cycle write.
//  - wr_acc: mem[wr_ptr]<=data_in, wr_ptr+1. rd_acc: rd_ptr+1. Pointers wrap modulo RAM_DEPTH.
//  - fill_count: +1 on wr_acc only, -1 on rd_acc only, unchanged on both/neither; never <0 or >RAM_DEPTH.
//  - Flags full/empty/almost_* combinational from registered fill_count (valid same cycle as count).
//  - overflow registered: high cycle after wr_req & full. underflow: cycle after rd_req & empty.
//  - Simultaneous wr_acc & rd_acc when count==1: legal, count stays 1, read returns the older word.
//  - Reset (sync, any cycle incl. mid-burst): wr_ptr=rd_ptr=0, fill_count=0, data_out=0, rd_valid=0,
//    overflow=underflow=0, empty=1, full=0, almost_empty=1, almost_full=0. Memory contents not cleared.
//  - No FSM: state is pointers + counter; ptr diff must always equal fill_count mod RAM_DEPTH.
// CONFIGURATION
//  SYN_FIFO_FWFT_EN undefined (default, standard mode):
//    data_out registered: on rd_acc, data_out <= mem[rd_ptr] next edge; holds otherwise.
//    rd_valid = 1-cycle pulse with the new data_out (read latency 1 clock).
//  SYN_FIFO_FWFT_EN defined (first-word-fall-through):
//    data_out = empty ? 0 : mem[rd_ptr] (combinational); rd_valid = !empty.
//    rd_en acts as acknowledge/pop; next word appears same cycle as updated rd_ptr.
//    Write into empty FIFO visible on data_out the cycle after the write edge.
// TESTING  (ADDR_WIDTH=4 -> depth 16, AF_LEVEL=14, AE_LEVEL=2, DATA_WIDTH=8)
//  1 Reset then idle -> empty=1, almost_empty=1, full=0, fill_count=0, data_out=0, rd_valid=0.
//  2 Write 0x00..0x0F, then 1 more write 0xAA -> full=1 after 16th, fill_count=16, almost_full from
//    14th write, overflow pulses once, 0xAA discarded; read 16 -> 0x00..0x0F in order, empty=1.
//  3 Read when empty -> underflow pulses 1 cycle, rd_valid=0, rd_ptr and fill_count unchanged.
//  4 Fill to 5, then 20 cycles simultaneous write/read -> fill_count stays 5, output order preserved
//    across pointer wrap (ptr 15->0).
//  5 Full + simultaneous wr/rd -> read accepted, write rejected, overflow=1, fill_count 16->15.
//  6 Assert rst mid-burst at fill_count=9 -> next cycle all outputs at reset values; FWFT build:
//    write 0x5A to empty -> data_out=0x5A, rd_valid=1 one cycle later with no rd_en.

Source files
------------

// File: rtl/syn_fifo_param.sv
// -----------------------------------------------------------------------------
// syn_fifo_param
// Parametrised single-clock FIFO with internal storage, true full at RAM_DEPTH
// entries, fill count, almost-full/almost-empty thresholds, overflow/underflow
// pulses and a read-valid strobe.
//
// Build option:
//   SYN_FIFO_FWFT_EN  undefined -> standard mode. data_out is registered and
//                     updates one clock after an accepted read. rd_valid
//                     pulses for one cycle together with the new word.
//                     defined   -> first-word-fall-through. data_out shows the
//                     head word whenever the FIFO is not empty. rd_en pops
//                     the head word, and rd_valid = !empty.
//
// Ports:
//   clk           in   clock, all logic on posedge
//   rst           in   synchronous reset, active-high
//   wr_cs/wr_en   in   write select / request (write needs both)
//   data_in       in   write data
//   rd_cs/rd_en   in   read select / request (read needs both)
//   data_out      out  read data
//   rd_valid      out  data_out carries a newly popped/presented word
//   full/empty    out  fill_count == RAM_DEPTH / fill_count == 0
//   almost_full   out  fill_count >= AF_LEVEL
//   almost_empty  out  fill_count <= AE_LEVEL
//   fill_count    out  stored words, 0..RAM_DEPTH
//   overflow      out  1-cycle pulse after a rejected write
//   underflow     out  1-cycle pulse after a rejected read
// -----------------------------------------------------------------------------
module syn_fifo_param #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int RAM_DEPTH  = 1 << ADDR_WIDTH,
    parameter int AF_LEVEL   = RAM_DEPTH - 4,
    parameter int AE_LEVEL   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_cs,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  rd_cs,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  rd_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   fill_count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH+1)'(RAM_DEPTH);
    localparam logic [ADDR_WIDTH:0] AF_CNT    = (ADDR_WIDTH+1)'(AF_LEVEL);
    localparam logic [ADDR_WIDTH:0] AE_CNT    = (ADDR_WIDTH+1)'(AE_LEVEL);

    logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;

    logic wr_req, rd_req, wr_acc, rd_acc;

    // Full/empty come from the registered count only. A read on a full FIFO
    // therefore does not free a slot for a write in the same cycle.
    assign full         = (fill_count == DEPTH_CNT);
    assign empty        = (fill_count == '0);
    assign almost_full  = (fill_count >= AF_CNT);
    assign almost_empty = (fill_count <= AE_CNT);

    assign wr_req = wr_cs & wr_en;
    assign rd_req = rd_cs & rd_en;
    assign wr_acc = wr_req & ~full;
    assign rd_acc = rd_req & ~empty;

    // Storage has no reset. Its contents are only ever observed through rd_ptr
    // after a write, so stale words are never visible.
    always_ff @(posedge clk) begin
        if (!rst && wr_acc) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fill_count <= '0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_acc, rd_acc})
                2'b10:   fill_count <= fill_count + 1'b1;
                2'b01:   fill_count <= fill_count - 1'b1;
                default: fill_count <= fill_count;
            endcase
            overflow  <= wr_req & full;
            underflow <= rd_req & empty;
        end
    end

`ifdef SYN_FIFO_FWFT_EN
    // The head word is presented directly. It is forced to zero when empty so
    // that stale storage never appears on the output.
    assign data_out = empty ? '0 : mem[rd_ptr];
    assign rd_valid = ~empty;
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_acc;
            if (rd_acc) begin
                data_out <= mem[rd_ptr];
            end
        end
    end
`endif

endmodule

// File: tb/tb_syn_fifo_param.sv
module tb_syn_fifo_param;
    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int AF    = 14;
    localparam int AE    = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_cs = 1'b0, wr_en = 1'b0, rd_cs = 1'b0, rd_en = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic [DW-1:0] data_out;
    logic          rd_valid, full, empty, almost_full, almost_empty;
    logic [AW:0]   fill_count;
    logic          overflow, underflow;

    syn_fifo_param #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AF_LEVEL(AF), .AE_LEVEL(AE)
    ) dut (
        .clk(clk), .rst(rst),
        .wr_cs(wr_cs), .wr_en(wr_en), .data_in(data_in),
        .rd_cs(rd_cs), .rd_en(rd_en),
        .data_out(data_out), .rd_valid(rd_valid),
        .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty),
        .fill_count(fill_count),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;

    // Reference model: a queue of stored words plus the expected registered outputs.
    logic [DW-1:0] q[$];
    logic [DW-1:0] m_dout  = '0;
    logic          m_rvalid = 1'b0;
    logic          m_ovf    = 1'b0;
    logic          m_unf    = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        int n;
        n = q.size();
        chk("fill_count",   32'(fill_count),   32'(n));
        chk("empty",        32'(empty),        32'(n == 0));
        chk("full",         32'(full),         32'(n == DEPTH));
        chk("almost_full",  32'(almost_full),  32'(n >= AF));
        chk("almost_empty", 32'(almost_empty), 32'(n <= AE));
`ifdef SYN_FIFO_FWFT_EN
        chk("data_out",     32'(data_out),     (n == 0) ? 32'd0 : 32'(q[0]));
        chk("rd_valid",     32'(rd_valid),     32'(n != 0));
`else
        chk("data_out",     32'(data_out),     32'(m_dout));
        chk("rd_valid",     32'(rd_valid),     32'(m_rvalid));
`endif
        chk("overflow",     32'(overflow),     32'(m_ovf));
        chk("underflow",    32'(underflow),    32'(m_unf));
    endtask

    // One clock: check the outputs against the model, drive the inputs, take the edge, advance the model.
    task automatic step(input logic r, input logic wcs, input logic wen,
                        input logic rcs, input logic ren, input logic [DW-1:0] d);
        logic wreq, rreq, was_full, was_empty;
        check_all();
        rst = r; wr_cs = wcs; wr_en = wen; rd_cs = rcs; rd_en = ren; data_in = d;
        @(posedge clk);
        if (r) begin
            q.delete();
            m_dout = '0; m_rvalid = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
        end else begin
            wreq      = wcs & wen;
            rreq      = rcs & ren;
            was_full  = (q.size() == DEPTH);
            was_empty = (q.size() == 0);
            m_ovf     = wreq & was_full;
            m_unf     = rreq & was_empty;
            m_rvalid  = 1'b0;
            if (rreq && !was_empty) begin
                m_dout   = q.pop_front();
                m_rvalid = 1'b1;
            end
            if (wreq && !was_full) q.push_back(d);
        end
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic wr(input logic [DW-1:0] d);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, d);
    endtask

    task automatic rd();
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, '0);
    endtask

    task automatic wrrd(input logic [DW-1:0] d);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, d);
    endtask

    initial begin
        int wp, rp;
        // 1: reset, then idle
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        idle();
        chk("t1_empty", 32'(empty), 32'd1);
        chk("t1_fill0", 32'(fill_count), 32'd0);

        // 2: fill 0x00..0x0F, one rejected write, drain in order
        for (int i = 0; i < DEPTH; i++) begin
            wr(8'(i));
            chk("t2_af", 32'(almost_full), 32'(i + 1 >= AF));
        end
        chk("t2_full", 32'(full), 32'd1);
        chk("t2_fill16", 32'(fill_count), 32'd16);
        wr(8'hAA);
        chk("t2_ovf_pulse", 32'(overflow), 32'd1);
        idle();
        chk("t2_ovf_clear", 32'(overflow), 32'd0);
        for (int i = 0; i < DEPTH; i++) begin
            rd();
`ifndef SYN_FIFO_FWFT_EN
            chk("t2_rd_data", 32'(data_out), 32'(i));
`endif
        end
        chk("t2_empty", 32'(empty), 32'd1);

        // 3: reads on an empty FIFO
        rd();
        chk("t3_unf", 32'(underflow), 32'd1);
        chk("t3_rvalid", 32'(rd_valid), 32'd0);
        rd();
        idle();
        chk("t3_unf_clear", 32'(underflow), 32'd0);

        // 4: fill to 5, then 20 cycles of simultaneous read/write across the pointer wrap
        for (int i = 0; i < 5; i++) wr(8'(8'h40 + i));
        for (int i = 0; i < 20; i++) begin
            wrrd(8'(8'h80 + i));
            chk("t4_fill5", 32'(fill_count), 32'd5);
        end
        repeat (5) rd();
        idle();

        // 5: full plus simultaneous read/write
        for (int i = 0; i < DEPTH; i++) wr(8'(8'hC0 + i));
        wrrd(8'h77);
        chk("t5_ovf", 32'(overflow), 32'd1);
        chk("t5_fill15", 32'(fill_count), 32'd15);
        repeat (DEPTH) rd();
        idle();

        // 6: reset in the middle of a write burst at fill_count 9
        for (int i = 0; i < 9; i++) wr(8'(8'h10 + i));
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h33);
        chk("t6_fill0", 32'(fill_count), 32'd0);
        chk("t6_empty", 32'(empty), 32'd1);
        chk("t6_dout0", 32'(data_out), 32'd0);
        wr(8'h5A);
`ifdef SYN_FIFO_FWFT_EN
        chk("t6_fwft_dout", 32'(data_out), 32'h5A);
        chk("t6_fwft_rvalid", 32'(rd_valid), 32'd1);
`endif
        idle();

        // Randomized traffic with shifting write/read bias and rare resets
        for (int blk = 0; blk < 15; blk++) begin
            wp = $urandom_range(10, 90);
            rp = $urandom_range(10, 90);
            for (int i = 0; i < 200; i++) begin
                step(($urandom_range(0, 299) == 0),
                     ($urandom_range(0, 9) != 0), ($urandom_range(0, 99) < wp),
                     ($urandom_range(0, 9) != 0), ($urandom_range(0, 99) < rp),
                     8'($urandom));
            end
        end
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
